song_recorder: RTL and testbench
================================

# song_recorder

Downstream stage of the lip-synth master. While the master reports COMPOSER, this block records the stream of held notes as (note, duration) segments into an on-chip buffer. When the buffer fills, it returns a one-cycle `done_recording` pulse to the master. While the master reports SONG_PLAYER, it replays the stored segments on `play_note` for the synthesiser voice.

## Interface
- `DEPTH`, 32: number of stored segments; power of two, ≥2.
- `DUR_W`, 12: width of the per-segment duration counter, in ticks.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. Returns all state to reset values.
- `state` in 2: master mode, encoded per package. JAM_SESH=0, COMPOSER=1, SONG_PLAYER=2; 3 is treated as JAM_SESH.
- `tick` in 1: one-cycle timebase strobe from the tempo divider.
- `key_code` in 6: currently held note, 1..56. 0 means rest/no key.
- `done_recording` out 1: one-cycle pulse to master when the buffer becomes full.
- `play_note` out 6: note being replayed; 0 when not playing.
- `play_active` out 1: high while a replay is in progress.
- `seg_count` out $clog2(DEPTH)+1: number of stored segments.

## Operation
- Internal FSM has three states: IDLE, RECORD, PLAY. A registered copy `state_q` detects mode entry, i.e. `state` differs from `state_q`.
- **Entry to COMPOSER:** `seg_count`←0, `wr_ptr`←0, `cur_note`←`key_code`, `dur`←0, FSM→RECORD. Each new COMPOSER entry erases the previous song.
- **RECORD**
  - On `tick`: `dur`←`dur`+1, saturating at 2^DUR_W−1. Saturation does not split the segment.
  - When `key_code`≠`cur_note` and `dur`>0: write {`cur_note`,`dur`} to `mem[wr_ptr]`, increment `wr_ptr` and `seg_count`, then `cur_note`←`key_code`, `dur`←0. Rests (note 0) are recorded as segments.
  - When `key_code`≠`cur_note` and `dur`=0: `cur_note`←`key_code` with no write, so glitches shorter than a tick are dropped.
  - Tick and key change in the same cycle: the tick is counted into the outgoing segment before the write.
  - A write that makes `seg_count`=DEPTH: pulse `done_recording`, FSM→IDLE.
  - `state` leaves COMPOSER: flush the pending segment if `dur`>0 and not full. No `done_recording` pulse. FSM→IDLE.
- **Entry to SONG_PLAYER** with `seg_count`>0: `rd_ptr`←0, FSM→PLAY. With `seg_count`=0: stay IDLE, outputs stay 0.
- **PLAY**
  - Load the entry at `rd_ptr`: `play_note`←note, `remain`←dur, `play_active`←1.
  - Each `tick` decrements `remain`. The tick that takes `remain` from 1 to 0 advances `rd_ptr` and loads the next entry.
  - After the last entry (`rd_ptr`=`seg_count`−1 expiring): behaviour depends on configuration.
  - `state` leaves SONG_PLAYER: FSM→IDLE, `play_note`←0, `play_active`←0 immediately.
- **JAM_SESH:** no writes, no playback. Buffer contents and `seg_count` are retained.
- **Reset:** FSM=IDLE, `done_recording`=0, `play_note`=0, `play_active`=0, `seg_count`=0. All pointers and counters are 0; memory contents are don't-care.

## Timing
- `state_q`, FSM, counters and all outputs are registered. Mode entry is acted on at the first edge where `state` shows the new value.
- `done_recording` goes high one cycle after the edge at which `key_code` change is sampled. It lasts exactly one cycle.
- Memory read is synchronous. `play_note`/`play_active` become valid 2 cycles after `state` first reads SONG_PLAYER. Advancing to the next entry also takes 2 cycles after the expiring tick; the previous note is held during the gap.
- Mid-operation reset overrides every other event in that cycle.

## Configuration
- `SONG_RECORDER_LOOP_EN` defined: after the last entry, `rd_ptr`←0 and replay repeats until SONG_PLAYER is left.
- `SONG_RECORDER_LOOP_EN` undefined: after the last entry, `play_active`←0, `play_note`←0, FSM→IDLE. There is no restart until SONG_PLAYER is re-entered.

## Structure
- Shared package `lip_synth_pkg` holds:
  - mode encodings (JAM_SESH, COMPOSER, SONG_PLAYER);
  - `NOTE_W`=6, `NOTE_REST`=0, `ROOT_MIN`=1, `ROOT_MAX`=56;
  - the segment record layout {note, dur}.
- Sub-module `song_mem`: simple dual-port RAM, DEPTH×(NOTE_W+DUR_W), one write port, synchronous read. Kept separate for BRAM inference.

## Test plan
- Reset with `state`=1 and `key_code`=5 → all outputs 0; `seg_count`=0 until reset deasserts.
- COMPOSER; `key_code`=5 for 3 ticks, then 7 for 2 ticks, then `state`=0 → `seg_count`=2, entries {5,3},{7,2}, no `done_recording`.
- DEPTH=4, COMPOSER; alternate `key_code` 3/4 with 1 tick each → fourth write gives a single-cycle `done_recording`; later key changes are ignored; `seg_count`=4.
- Change `key_code` 5→9→5 within one tick interval → no segment written; `cur_note`=5 continues.
- Key change and `tick` in the same cycle with `dur`=2 → segment written with dur=3.
- SONG_PLAYER after the {5,3},{7,2} recording → `play_note`=5 for 3 ticks, 7 for 2 ticks, then 0. With LOOP_EN, 5 again. Switching `state` to 0 mid-note → `play_note`=0 next cycle.

Source files
------------

// File: rtl/lip_synth_pkg.sv
// Shared encodings for the lip-synth master and its downstream stages.
// Mode values, note range and the stored segment layout {note, dur}.
// No latency or backpressure: declarations only.
package lip_synth_pkg;
    typedef enum logic [1:0] {
        JAM_SESH    = 2'd0,
        COMPOSER    = 2'd1,
        SONG_PLAYER = 2'd2
    } mode_e;

    localparam int                NOTE_W    = 6;
    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
    localparam logic [NOTE_W-1:0] ROOT_MIN  = 6'd1;
    localparam logic [NOTE_W-1:0] ROOT_MAX  = 6'd56;
    localparam int                SEG_DUR_W = 12;

    // Segment record: note in the upper bits, held duration in ticks below.
    typedef struct packed {
        logic [NOTE_W-1:0]    note;
        logic [SEG_DUR_W-1:0] dur;
    } seg_t;

    // Encoding 3 is reserved by the master and behaves as JAM_SESH here.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == 2'd3) ? JAM_SESH : mode_e'(raw);
    endfunction
endpackage

// File: rtl/song_mem.sv
// Segment store: simple dual-port RAM, one write port and one read port.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none, both ports accept every cycle.
module song_mem #(
    parameter int DEPTH = 32,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [W-1:0]             rd_dat_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/song_recorder.sv
// Records (note, duration) segments in COMPOSER, replays them in SONG_PLAYER; SONG_RECORDER_LOOP_EN repeats replay.
// Latency: outputs registered; first note and each next note appear 2 cycles after the entry/expiring tick.
// Backpressure: none, tick and key_code are sampled every cycle.
module song_recorder
    import lip_synth_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DUR_W = SEG_DUR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               state,
    input  logic                     tick,
    input  logic [NOTE_W-1:0]        key_code,
    output logic                     done_recording,
    output logic [NOTE_W-1:0]        play_note,
    output logic                     play_active,
    output logic [$clog2(DEPTH):0]   seg_count
);
    localparam int               AW       = $clog2(DEPTH);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [AW:0]      SEG_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} fsm_e;
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rec_t;

    logic [1:0]        state_q;
    fsm_e              fsm_q;
    logic [AW:0]       seg_count_q, seg_count_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [NOTE_W-1:0] cur_note_q;
    logic [DUR_W-1:0]  dur_q, dur_d, remain_q;
    logic              load_q, done_q, play_active_q;
    logic [NOTE_W-1:0] play_note_q;

    mode_e mode;
    logic  mode_entry, wr_en, play_start, expire, last_seg;
    rec_t  wr_rec, rd_rec;
    logic [NOTE_W+DUR_W-1:0] rd_dat;

    always_comb begin
        mode        = decode_mode(state);
        mode_entry  = (state != state_q);
        // A tick in the same cycle as a key change belongs to the outgoing segment.
        dur_d       = (tick && dur_q != DUR_MAX) ? dur_q + 1'b1 : dur_q;
        wr_en       = (fsm_q == S_RECORD) && (dur_d != '0)
                      && ((mode != COMPOSER) || (key_code != cur_note_q));
        wr_rec      = '{note: cur_note_q, dur: dur_d};
        seg_count_d = seg_count_q + {{AW{1'b0}}, wr_en};
        play_start  = (mode == SONG_PLAYER) && mode_entry && (fsm_q != S_PLAY)
                      && (seg_count_d != '0);
        last_seg    = ({1'b0, rd_ptr_q} + 1'b1) == seg_count_q;
        expire      = (fsm_q == S_PLAY) && (mode == SONG_PLAYER) && !load_q
                      && tick && (remain_q == DUR_ONE);
        rd_ptr_d    = rd_ptr_q;
        if (play_start) begin
            rd_ptr_d = '0;
        end else if (expire) begin
            rd_ptr_d = last_seg ? '0 : rd_ptr_q + 1'b1;
        end
    end

    song_mem #(.DEPTH(DEPTH), .W(NOTE_W + DUR_W)) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (wr_rec),
        .rd_addr_i (rd_ptr_d),
        .rd_dat_o  (rd_dat)
    );
    assign rd_rec = rec_t'(rd_dat);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= 2'd0;
            fsm_q         <= S_IDLE;
            seg_count_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cur_note_q    <= NOTE_REST;
            dur_q         <= '0;
            remain_q      <= '0;
            load_q        <= 1'b0;
            done_q        <= 1'b0;
            play_note_q   <= NOTE_REST;
            play_active_q <= 1'b0;
        end else begin
            state_q  <= state;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            if (mode == COMPOSER && mode_entry) begin
                seg_count_q   <= '0;
                wr_ptr_q      <= '0;
                cur_note_q    <= key_code;
                dur_q         <= '0;
                fsm_q         <= S_RECORD;
                play_note_q   <= NOTE_REST;
                play_active_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q    <= wr_ptr_q + 1'b1;
                    seg_count_q <= seg_count_d;
                end
                case (fsm_q)
                    S_RECORD: begin
                        if (mode != COMPOSER) begin
                            fsm_q  <= play_start ? S_PLAY : S_IDLE;
                            load_q <= play_start;
                        end else if (key_code != cur_note_q) begin
                            cur_note_q <= key_code;
                            dur_q      <= '0;
                            if (seg_count_d == SEG_FULL) begin
                                done_q <= 1'b1;
                                fsm_q  <= S_IDLE;
                            end
                        end else begin
                            dur_q <= dur_d;
                        end
                    end
                    S_PLAY: begin
                        if (mode != SONG_PLAYER) begin
                            fsm_q         <= S_IDLE;
                            play_note_q   <= NOTE_REST;
                            play_active_q <= 1'b0;
                        end else if (load_q) begin
                            play_note_q   <= rd_rec.note;
                            remain_q      <= rd_rec.dur;
                            play_active_q <= 1'b1;
                        end else if (tick) begin
                            remain_q <= remain_q - 1'b1;
                            if (expire) begin
                                if (last_seg) begin
`ifdef SONG_RECORDER_LOOP_EN
                                    load_q <= 1'b1;
`else
                                    fsm_q         <= S_IDLE;
                                    play_note_q   <= NOTE_REST;
                                    play_active_q <= 1'b0;
`endif
                                end else begin
                                    load_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (play_start) begin
                            fsm_q  <= S_PLAY;
                            load_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign done_recording = done_q;
    assign play_note      = play_note_q;
    assign play_active    = play_active_q;
    assign seg_count      = seg_count_q;
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with a 4-entry buffer; expectations are hand-derived.
module tb_song_recorder;
    localparam int DEPTH = 4;
    localparam int DUR_W = 12;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             state;
    logic                   tick;
    logic [5:0]             key_code;
    logic                   done_recording;
    logic [5:0]             play_note;
    logic                   play_active;
    logic [$clog2(DEPTH):0] seg_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    song_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .tick           (tick),
        .key_code       (key_code),
        .done_recording (done_recording),
        .play_note      (play_note),
        .play_active    (play_active),
        .seg_count      (seg_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (done_recording === 1'b1) done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1; state = 2'd1; key_code = 6'd5; tick = 1'b0;
        cyc();
        check("rst_note", play_note, 0);
        check("rst_active", play_active, 0);
        check("rst_done", done_recording, 0);
        check("rst_seg", seg_count, 0);
        cyc(); cyc();
        check("rst_seg_hold", seg_count, 0);

        // Record {5,3},{7,2}
        reset = 1'b0;
        cyc();
        check("rec_entry_seg", seg_count, 0);
        ticks(3);
        key_code = 6'd7;
        cyc();
        check("rec_seg1", seg_count, 1);
        ticks(2);
        state = 2'd0;
        cyc();
        check("rec_flush_seg", seg_count, 2);
        check("rec_no_done", done_cnt, 0);
        cyc();
        check("jam_retain_seg", seg_count, 2);

        // Replay
        state = 2'd2;
        cyc();
        check("play_lat_active", play_active, 0);
        cyc();
        check("play_first_note", play_note, 5);
        check("play_first_active", play_active, 1);
        ticks(2);
        check("play_note5_hold", play_note, 5);
        tick = 1'b1; cyc(); tick = 1'b0;
        check("play_gap_hold", play_note, 5);
        cyc();
        check("play_second_note", play_note, 7);
        ticks(1);
        check("play_note7_hold", play_note, 7);
        tick = 1'b1; cyc(); tick = 1'b0;
`ifdef SONG_RECORDER_LOOP_EN
        check("loop_gap_note", play_note, 7);
        check("loop_gap_active", play_active, 1);
        cyc();
        check("loop_restart_note", play_note, 5);
`else
        check("end_note", play_note, 0);
        check("end_active", play_active, 0);
        cyc();
        check("end_note_stays", play_note, 0);
`endif

        // Re-entry, then leave mid-note via encoding 3
        state = 2'd0; cyc();
        state = 2'd2; cyc(); cyc();
        check("replay_note", play_note, 5);
        tick = 1'b1; cyc(); tick = 1'b0;
        state = 2'd3;
        cyc();
        check("leave_note", play_note, 0);
        check("leave_active", play_active, 0);

        // Glitch drop and same-cycle tick/key change
        state = 2'd1; key_code = 6'd5;
        cyc();
        check("erase_seg", seg_count, 0);
        key_code = 6'd9; cyc();
        key_code = 6'd5; cyc();
        check("glitch_seg", seg_count, 0);
        ticks(2);
        key_code = 6'd6; tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("same_cycle_seg", seg_count, 1);
        ticks(1);
        state = 2'd0;
        cyc();
        check("glitch_flush_seg", seg_count, 2);
        state = 2'd2; cyc(); cyc();
        check("glitch_first_note", play_note, 5);
        ticks(2);
        check("dur3_hold", play_note, 5);
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        check("same_cycle_next", play_note, 6);
        state = 2'd0; cyc();

        // Fill the buffer
        done_cnt = 0;
        state = 2'd1; key_code = 6'd3;
        cyc();
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            key_code = (i % 2 == 0) ? 6'd4 : 6'd3;
            cyc();
            check("fill_done", done_recording, (i == 3) ? 1 : 0);
            check("fill_seg", seg_count, i + 1);
        end
        cyc();
        check("done_one_cycle", done_recording, 0);
        ticks(1); key_code = 6'd4; cyc();
        ticks(1); key_code = 6'd3; cyc();
        check("full_ignore_seg", seg_count, 4);
        check("done_count", done_cnt, 1);
        state = 2'd0; cyc();
        state = 2'd2; cyc(); cyc();
        check("full_play_first", play_note, 3);
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        check("full_play_second", play_note, 4);

        // Mid-operation reset, then an empty buffer must not start replay
        reset = 1'b1;
        cyc();
        check("midrst_note", play_note, 0);
        check("midrst_active", play_active, 0);
        check("midrst_seg", seg_count, 0);
        reset = 1'b0;
        cyc(); cyc(); cyc();
        check("empty_play_active", play_active, 0);
        check("empty_play_note", play_note, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
